// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines,
// assembles 11-bit frames, checks odd parity and the stop bit, and turns
// E0/F0/E1 prefixed byte sequences into a single scancode strobe.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       scan_received,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // The filter counter only has to reach FILTER_LEN-1 before the flip.
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] FILT_LAST    = FCW'(FILTER_LEN - 1);
  localparam logic [15:0]    TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic           ps2clk_s1_reg, ps2clk_s2_reg;
  logic           ps2data_s1_reg, ps2data_s2_reg;
  logic           ps2clk_filt_reg, ps2clk_prev_reg;
  logic [FCW-1:0] filt_cnt_reg;
  logic           fall_edge;

  state_t         state_reg, state_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shift_reg, shift_next;
  logic           parity_reg, parity_next;
  logic [15:0]    idle_cnt_reg;
  logic           byte_ok, byte_bad, timeout_hit;

  logic           e0_reg, f0_reg;
  logic [2:0]     skip_cnt_reg;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2clk_s1_reg  <= 1'b1;
      ps2clk_s2_reg  <= 1'b1;
      ps2data_s1_reg <= 1'b1;
      ps2data_s2_reg <= 1'b1;
    end else begin
      ps2clk_s1_reg  <= ps2clk_in;
      ps2clk_s2_reg  <= ps2clk_s1_reg;
      ps2data_s1_reg <= ps2data_in;
      ps2data_s2_reg <= ps2data_s1_reg;
    end
  end

  // Clock de-glitch: flip only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2clk_filt_reg <= 1'b1;
      ps2clk_prev_reg <= 1'b1;
      filt_cnt_reg    <= '0;
    end else begin
      ps2clk_prev_reg <= ps2clk_filt_reg;
      if (ps2clk_s2_reg != ps2clk_filt_reg) begin
        if (filt_cnt_reg == FILT_LAST) begin
          ps2clk_filt_reg <= ps2clk_s2_reg;
          filt_cnt_reg    <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + FCW'(1);
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall_edge = ps2clk_prev_reg & ~ps2clk_filt_reg;

  // Frame FSM next-state: one bit per filtered falling edge, plus timeout abort.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    byte_ok      = 1'b0;
    byte_bad     = 1'b0;
    timeout_hit  = 1'b0;
    if (fall_edge) begin
      case (state_reg)
        IDLE: begin
          if (!ps2data_s2_reg) begin
            state_next   = DATA;
            bit_cnt_next = 3'd0;
          end
        end
        DATA: begin
          shift_next   = {ps2data_s2_reg, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = ps2data_s2_reg;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (ps2data_s2_reg && (^{shift_reg, parity_reg})) byte_ok  = 1'b1;
          else                                               byte_bad = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if ((state_reg != IDLE) && (idle_cnt_reg == TIMEOUT_LAST)) begin
      timeout_hit = 1'b1;
      state_next  = IDLE;
    end
  end

  // Frame FSM registers and the inter-edge idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      idle_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      if (fall_edge || (state_reg == IDLE)) idle_cnt_reg <= '0;
      else                                  idle_cnt_reg <= idle_cnt_reg + 16'd1;
    end
  end

  // Byte decoder: prefix flags, Pause swallowing, output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_reg        <= 1'b0;
      f0_reg        <= 1'b0;
      skip_cnt_reg  <= '0;
      scan_received <= 1'b0;
      frame_error   <= 1'b0;
      scancode      <= 8'h00;
      extended      <= 1'b0;
      released      <= 1'b0;
    end else begin
      scan_received <= 1'b0;
      frame_error   <= 1'b0;
      if (byte_bad || timeout_hit) begin
        frame_error  <= 1'b1;
        e0_reg       <= 1'b0;
        f0_reg       <= 1'b0;
        skip_cnt_reg <= '0;
      end else if (byte_ok) begin
        if (skip_cnt_reg != 3'd0) begin
          skip_cnt_reg <= skip_cnt_reg - 3'd1;
        end else begin
          case (shift_reg)
            8'hE1: skip_cnt_reg <= 3'd7;
            8'hE0: e0_reg <= 1'b1;
            8'hF0: f0_reg <= 1'b1;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
              e0_reg <= 1'b0;
              f0_reg <= 1'b0;
            end
            default: begin
              scancode      <= shift_reg;
              extended      <= e0_reg;
              released      <= f0_reg;
              scan_received <= 1'b1;
              e0_reg        <= 1'b0;
              f0_reg        <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
